// File: rtl/regfile_scoreboard.sv
// Multi-port register file with per-register pending-write scoreboard.
// x0 reads as zero, is never written and is never tracked.
module regfile_rd_port #(
  parameter int  DATA_WIDTH = 32,
  parameter int  ADDR_WIDTH = 5,
  parameter int  PEND_WIDTH = 2,
  parameter int  BYPASS     = 1,
  localparam int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]                  raddr,
  input  logic                                   we,
  input  logic [ADDR_WIDTH-1:0]                  waddr,
  input  logic [DATA_WIDTH-1:0]                  wdata,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0]       regs,
  input  logic [DEPTH-1:0][PEND_WIDTH-1:0]       cnt,
  input  logic [DEPTH-1:0]                       dec,
  output logic [DATA_WIDTH-1:0]                  rdata,
  output logic                                   busy
);
  localparam logic BP = (BYPASS != 0);

  logic nz, hit;

  assign nz    = (raddr != '0);
  assign hit   = BP && we && (waddr == raddr);
  assign rdata = !nz ? '0 : (hit ? wdata : regs[raddr]);
  // With bypass, a writeback retiring the last pending write releases the reader now.
  assign busy  = nz && (cnt[raddr] != '0) &&
                 !(BP && dec[raddr] && (cnt[raddr] == PEND_WIDTH'(1)));
endmodule

module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int PEND_WIDTH = 2,
  parameter int BYPASS     = 1,
  parameter int DEBUG_REG  = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
  input  logic                           alloc_en,
  input  logic [ADDR_WIDTH-1:0]          alloc_addr,
  output logic                           alloc_stall,
  output logic [NUM_READ-1:0]            busy,
  output logic [DATA_WIDTH-1:0]          dbg
);
  localparam int                    DEPTH   = 2**ADDR_WIDTH;
  localparam logic [PEND_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] DBG_IDX = ADDR_WIDTH'(DEBUG_REG);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0][PEND_WIDTH-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]                 inc, dec;
  logic                             we_g, alloc_g;

  // Inputs are ignored while reset is held, so every output reads zero.
  assign we_g    = we & ~rst;
  assign alloc_g = alloc_en & ~rst;

  always_comb begin
    dec = '0;
    for (int r = 1; r < DEPTH; r++)
      dec[r] = we_g && (waddr == ADDR_WIDTH'(r)) && (cnt_q[r] != '0);
  end

  assign alloc_stall = alloc_g && (alloc_addr != '0) &&
                       (cnt_q[alloc_addr] == CNT_MAX) && !dec[alloc_addr];

  always_comb begin
    inc = '0;
    for (int r = 1; r < DEPTH; r++)
      inc[r] = alloc_g && !alloc_stall && (alloc_addr == ADDR_WIDTH'(r));
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (inc[r] && !dec[r])      cnt_d[r] = cnt_q[r] + PEND_WIDTH'(1);
      else if (dec[r] && !inc[r]) cnt_d[r] = cnt_q[r] - PEND_WIDTH'(1);
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    regs_d = regs_q;
    if (we_g && (waddr != '0)) regs_d[waddr] = wdata;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dbg = regs_q[DBG_IDX];

  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    regfile_rd_port #(
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .PEND_WIDTH(PEND_WIDTH), .BYPASS(BYPASS)
    ) u_rd (
      .raddr (raddr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .we    (we_g),
      .waddr (waddr),
      .wdata (wdata),
      .regs  (regs_q),
      .cnt   (cnt_q),
      .dec   (dec),
      .rdata (rdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .busy  (busy[g])
    );
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_regfile_scoreboard;
  logic        clk = 0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [14:0] raddr;
  logic [95:0] rdata;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        alloc_stall;
  logic [2:0]  busy;
  logic [31:0] dbg;
  logic [31:0] rdata_nb, dbg_nb;
  logic        alloc_stall_nb;
  logic [0:0]  busy_nb;

  always #5 clk = ~clk;

  regfile_scoreboard #(.NUM_READ(3), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .alloc_stall(alloc_stall), .busy(busy), .dbg(dbg));

  regfile_scoreboard #(.NUM_READ(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr[4:0]), .rdata(rdata_nb), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .alloc_stall(alloc_stall_nb), .busy(busy_nb), .dbg(dbg_nb));

  typedef struct { string name; int sel; logic [31:0] exp; } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // sel: 0..2 rdata port, 3 busy vector, 4 alloc_stall, 5 dbg,
  //      6 no-bypass rdata, 7 no-bypass busy, 8 no-bypass alloc_stall
  function automatic logic [31:0] actual(int sel);
    case (sel)
      0: return rdata[31:0];
      1: return rdata[63:32];
      2: return rdata[95:64];
      3: return {29'b0, busy};
      4: return {31'b0, alloc_stall};
      5: return dbg;
      6: return rdata_nb;
      7: return {31'b0, busy_nb};
      8: return {31'b0, alloc_stall_nb};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_v(string name, int sel, logic [31:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(logic w, logic [4:0] wa, logic [31:0] wd,
                       logic a, logic [4:0] aa,
                       logic [4:0] r0, logic [4:0] r1, logic [4:0] r2);
    we = w; waddr = wa; wdata = wd; alloc_en = a; alloc_addr = aa;
    raddr = {r2, r1, r0};
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = actual(e.sel);
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    drive(1, 5'd5, 32'hCAFE_F00D, 1, 5'd5, 5'd5, 5'd0, 5'd0);
    #1;
    expect_v("rst_rdata_ignores_we", 0, 0);
    expect_v("rst_busy",             3, 0);
    expect_v("rst_stall",            4, 0);
    expect_v("rst_dbg",              5, 0);
    step(); step();
    rst = 0;
    drive(0, 0, 0, 0, 0, 5'd5, 5'd0, 5'd0);
    expect_v("post_rst_x5", 0, 0);

    // Write x5 and x10 then reset mid-cycle
    step(); drive(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 5'd5, 5'd0, 5'd0);
    expect_v("wr_x5_bypass", 0, 32'hDEAD_BEEF);
    expect_v("wr_x5_nb_old", 6, 0);
    step(); drive(1, 5'd10, 32'h0000_0ABC, 0, 0, 5'd5, 5'd0, 5'd0);
    expect_v("x5_stored",    0, 32'hDEAD_BEEF);
    expect_v("x5_stored_nb", 6, 32'hDEAD_BEEF);
    step(); drive(0, 0, 0, 0, 0, 5'd5, 5'd0, 5'd0);
    expect_v("dbg_x10", 5, 32'h0000_0ABC);
    step(); rst = 1;
    expect_v("midrst_rdata", 0, 0);
    expect_v("midrst_busy",  3, 0);
    expect_v("midrst_dbg",   5, 0);
    step(); rst = 0;
    expect_v("after_rst_x5", 0, 0);

    // x0 protection
    step(); drive(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 5'd0, 5'd0, 5'd0);
    expect_v("x0_write_read", 0, 0);
    expect_v("x0_alloc_stall", 4, 0);
    step(); drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    expect_v("x0_after", 0, 0);
    expect_v("x0_busy",  3, 0);

    // Bypass vs no-bypass on x7
    step(); drive(1, 5'd7, 32'h11, 0, 0, 5'd7, 5'd0, 5'd0);
    step(); drive(1, 5'd7, 32'h22, 0, 0, 5'd7, 5'd0, 5'd0);
    expect_v("byp_same_cycle", 0, 32'h22);
    expect_v("nobyp_old",      6, 32'h11);
    step(); drive(0, 0, 0, 0, 0, 5'd7, 5'd0, 5'd0);
    expect_v("byp_next",   0, 32'h22);
    expect_v("nobyp_next", 6, 32'h22);

    // Scoreboard fill on x3
    step(); drive(0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 5'd0);
    expect_v("alloc1_stall", 4, 0);
    expect_v("alloc1_busy",  3, 0);
    step();
    expect_v("alloc2_stall", 4, 0);
    expect_v("alloc2_busy",  3, 3'b001);
    step();
    expect_v("alloc3_stall", 4, 0);
    expect_v("alloc3_busy",  3, 3'b001);
    step();
    expect_v("alloc4_stall",    4, 1);
    expect_v("alloc4_stall_nb", 8, 1);
    step(); drive(0, 0, 0, 0, 0, 5'd3, 5'd0, 5'd0);
    expect_v("full_busy",    3, 3'b001);
    expect_v("full_busy_nb", 7, 1);

    // Simultaneous alloc + writeback at cnt=3
    step(); drive(1, 5'd3, 32'h33, 1, 5'd3, 5'd3, 5'd0, 5'd0);
    expect_v("simul_stall", 4, 0);
    expect_v("simul_busy",  3, 3'b001);
    expect_v("simul_rdata", 0, 32'h33);
    step(); drive(0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 5'd0);
    expect_v("simul_cnt_still3", 4, 1);
    expect_v("simul_stored",     0, 32'h33);

    // Drain with three writebacks
    step(); drive(1, 5'd3, 32'h41, 0, 0, 5'd3, 5'd0, 5'd0);
    expect_v("wb1_busy", 3, 3'b001);
    step(); drive(1, 5'd3, 32'h42, 0, 0, 5'd3, 5'd0, 5'd0);
    expect_v("wb2_busy", 3, 3'b001);
    step(); drive(1, 5'd3, 32'h43, 0, 0, 5'd3, 5'd0, 5'd0);
    expect_v("wb3_busy_byp",  3, 0);
    expect_v("wb3_busy_nb",   7, 1);
    step(); drive(1, 5'd3, 32'h44, 0, 0, 5'd3, 5'd0, 5'd0);
    expect_v("drained_busy",    3, 0);
    expect_v("drained_busy_nb", 7, 0);
    expect_v("drained_rdata_nb", 6, 32'h43);
    step(); drive(0, 0, 0, 0, 0, 5'd3, 5'd0, 5'd0);
    expect_v("no_underflow_busy", 3, 0);
    expect_v("extra_wr_stored",   0, 32'h44);

    // Multi-port and dbg
    step(); drive(1, 5'd10, 32'h1234, 0, 0, 5'd10, 5'd10, 5'd0);
    expect_v("mp_byp_p0",   0, 32'h1234);
    expect_v("mp_byp_p1",   1, 32'h1234);
    expect_v("mp_byp_p2",   2, 0);
    expect_v("dbg_no_byp",  5, 0);
    step(); drive(0, 0, 0, 1, 5'd10, 5'd10, 5'd10, 5'd0);
    expect_v("mp_p0",  0, 32'h1234);
    expect_v("mp_p1",  1, 32'h1234);
    expect_v("mp_p2",  2, 0);
    expect_v("mp_dbg", 5, 32'h1234);
    expect_v("alloc_busy_same_cycle", 3, 0);
    step(); drive(0, 0, 0, 0, 0, 5'd10, 5'd3, 5'd10);
    expect_v("mp_busy_vec", 3, 3'b101);

    // Reset discards outstanding allocation on x10
    step(); rst = 1;
    expect_v("rst_alloc_busy", 3, 0);
    step(); rst = 0;
    expect_v("rst_cleared_busy", 3, 0);
    expect_v("rst_cleared_rd",   0, 0);

    step(); step();
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
